if_stage: RTL
=============

Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Owns the PC register and drives the address of the asynchronous-read instruction memory.
- Captures the returned word into the IF/ID pipeline register for the decode stage.
- Handles stall, flush and branch/jump redirect from the hazard/branch logic, and keeps a fetch counter.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- NOP_INSTR, 32'h00000000, bubble encoding inserted into IF/ID (sll $0,$0,0).
- EXC_VECTOR, 32'h00000080, PC loaded on misaligned redirect (optional feature only).

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- stall_if  in  1  hold PC and IF/ID (load-use hazard).
- flush_id  in  1  load bubble into IF/ID at next edge.
- redirect_valid  in  1  branch/jump taken; load redirect_target into PC.
- redirect_target  in  32  new PC.
- imem_addr  out  32  instruction memory address (= pc).
- imem_instr  in  32  instruction word returned same cycle.
- pc  out  32  current PC register.
- id_instr  out  32  IF/ID instruction.
- id_pc_plus4  out  32  IF/ID PC+4 (for branch target / jal link).
- id_valid  out  1  IF/ID holds a real instruction.
- fetch_count  out  32  number of instructions delivered into IF/ID.
- misalign_exc  out  1  IF/ID carries a misaligned-redirect exception (0 when feature disabled).

Behaviour:
- Reset is synchronous. On a clock edge with reset=1:
  - pc <= RESET_PC, id_instr <= NOP_INSTR, id_pc_plus4 <= 0.
  - id_valid <= 0, fetch_count <= 0, misalign_exc <= 0.
  - Reset asserted mid-operation discards all in-flight state on that edge.
- imem_addr = pc, purely combinational; memory read is zero-latency.
- Instruction at pc appears in id_instr one edge later.
- PC next-value priority, per edge:
  - reset > redirect_valid > stall_if > pc+4.
  - pc+4 is modulo 2^32: 32'hFFFFFFFC -> 32'h00000000.
- IF/ID next-value priority, per edge:
  - reset > (redirect_valid | flush_id) > stall_if > capture.
  - Capture: id_instr <= imem_instr, id_pc_plus4 <= pc+4, id_valid <= 1.
  - Bubble: id_instr <= NOP_INSTR, id_pc_plus4 <= 0, id_valid <= 0.
  - Stall: all IF/ID registers hold their values.
- Redirect squashes the wrong-path instruction currently being fetched (single-cycle branch penalty, no delay slot).
- redirect_valid together with stall_if: redirect wins; PC is loaded and IF/ID is bubbled.
- flush_id together with stall_if (no redirect): IF/ID is bubbled and PC holds.
- fetch_count increments by 1 on every edge where a capture occurs (id_valid becomes/stays 1 via capture). It holds on stall, bubble or redirect and wraps at 2^32.
- No combinational path from any input to pc, id_*, or fetch_count.
- misalign_exc is tied 0 when the optional feature is disabled.

Optional Feature:
- Macro: IF_MISALIGN_EXC_EN.
- Defined: when redirect_valid=1 and redirect_target[1:0] != 2'b00:
  - pc <= EXC_VECTOR instead of the target.
  - IF/ID is bubbled.
  - misalign_exc <= 1 for exactly one IF/ID cycle, cleared by the next capture, bubble or reset; it holds during stall.
  - fetch_count is unaffected.
- Not defined:
  - Target is loaded unmodified; low bits are ignored by memory indexing.
  - misalign_exc is constant 0; no EXC_VECTOR logic is synthesised.

Test Plan:
- Reset, then 3 free-running edges with memory returning 20100000, 8e110000, 00005020 at addresses 0, 4, 8:
  - pc = 0 -> 4 -> 8 -> C.
  - id_instr follows one edge behind: 20100000, 8e110000, 00005020.
  - id_pc_plus4 = 4, 8, C; fetch_count = 3.
- stall_if held 2 cycles at pc = 8:
  - pc stays 8; id_instr stays 8e110000; fetch_count unchanged.
  - After release, the next edge captures address 8.
- redirect_valid = 1 with target 0x24 at pc = 0x1C:
  - Next edge: pc = 0x24, id_instr = 0, id_valid = 0.
  - Following edge: the instruction from 0x24 is in IF/ID with id_pc_plus4 = 0x28.
- redirect_valid and stall_if asserted together with target 0x40:
  - pc = 0x40, IF/ID bubbled.
- flush_id with stall_if (no redirect): pc held, IF/ID bubbled.
- pc = 32'hFFFFFFFC: next pc = 0.
- reset asserted for 1 cycle mid-run at pc = 0x30: all outputs return to reset values on that edge.
- Feature enabled, redirect target 0x22: pc = 0x80, misalign_exc = 1 for one cycle.
- Feature disabled, same stimulus: pc = 0x22, misalign_exc = 0.

Source files
------------

// File: rtl/if_stage.sv
// if_stage: MIPS instruction-fetch stage with PC, IF/ID register and fetch counter; optional IF_MISALIGN_EXC_EN
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h00000000,
  parameter logic [31:0] NOP_INSTR  = 32'h00000000,
  parameter logic [31:0] EXC_VECTOR = 32'h00000080
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_if,
  input  logic        flush_id,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] pc,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid,
  output logic [31:0] fetch_count,
  output logic        misalign_exc
);
  logic [31:0] pc_q, pc_d, instr_q, instr_d, pc4_q, pc4_d, cnt_q, cnt_d, redir_pc, pc_plus4;
  logic        valid_q, valid_d, bubble;
`ifdef IF_MISALIGN_EXC_EN
  logic exc_q, exc_d, mis;
  assign mis      = redirect_valid & |redirect_target[1:0];
  assign redir_pc = mis ? EXC_VECTOR : redirect_target;
  // exception flag rides with the bubble it created and holds across stalls
  always_comb exc_d = bubble ? mis : stall_if ? exc_q : 1'b0;
  // exception flag register
  always_ff @(posedge clk) exc_q <= reset ? 1'b0 : exc_d;
  assign misalign_exc = exc_q;
`else
  logic unused_exc;
  assign unused_exc   = ^EXC_VECTOR;
  assign redir_pc     = redirect_target;
  assign misalign_exc = 1'b0;
`endif
  // next PC and IF/ID contents: redirect beats flush beats stall beats capture
  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    bubble   = redirect_valid | flush_id;
    pc_d     = redirect_valid ? redir_pc : stall_if ? pc_q : pc_plus4;
    instr_d  = bubble ? NOP_INSTR : stall_if ? instr_q : imem_instr;
    pc4_d    = bubble ? 32'd0 : stall_if ? pc4_q : pc_plus4;
    valid_d  = bubble ? 1'b0 : stall_if ? valid_q : 1'b1;
    cnt_d    = cnt_q + {31'd0, ~bubble & ~stall_if};
  end
  // pipeline state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
      cnt_q   <= 32'd0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign id_instr    = instr_q;
  assign id_pc_plus4 = pc4_q;
  assign id_valid    = valid_q;
  assign fetch_count = cnt_q;
endmodule
